// File: rtl/net_packet_trace_buffer_pkg.sv
// Shared types for the packet trace buffer: network packet format, trace entry layout,
// capture state encoding and the capture-eligibility helper.
package net_packet_trace_buffer_pkg;

  localparam int net_op_width_gp = 3;
  localparam int id_width_gp     = 8;
  localparam int data_width_gp   = 32;

  typedef enum logic [net_op_width_gp-1:0] {
    OP_NULL  = 3'd0,
    OP_REG   = 3'd1,
    OP_PC    = 3'd2,
    OP_INSTR = 3'd3,
    OP_MEM   = 3'd4,
    OP_CSR   = 3'd5,
    OP_IRQ   = 3'd6,
    OP_DBG   = 3'd7
  } net_op_e;

  typedef struct packed {
    net_op_e                  net_op;
    logic [id_width_gp-1:0]   id;
    logic [data_width_gp-1:0] data;
  } net_packet_s;

  typedef struct packed {
    logic [31:0] cycle;
    logic [2:0]  chan;
    net_packet_s pkt;
  } trace_entry_s;

  typedef enum logic [1:0] {
    TRACE_IDLE   = 2'd0,
    TRACE_ARMED  = 2'd1,
    TRACE_POST   = 2'd2,
    TRACE_FROZEN = 2'd3
  } trace_state_e;

  // A packet is worth tracing when it is not idle and its op is enabled in the filter mask
  function automatic logic pkt_capturable(input net_packet_s p,
                                          input logic [(1<<net_op_width_gp)-1:0] filter);
    return (p.net_op != OP_NULL) && filter[p.net_op];
  endfunction

endpackage

// File: rtl/net_packet_trace_buffer_if.sv
// Capture and read-back bus of the trace buffer: per-channel packet inputs with the shared
// timestamp, plus the registered read port. The buffer is the slave side.
interface net_packet_trace_buffer_if
  import net_packet_trace_buffer_pkg::*;
#(
  parameter int channels_p = 4,
  parameter int depth_p    = 64
);

  net_packet_s [channels_p-1:0] net_packet;
  logic [31:0]                  cycle_counter;
  logic [$clog2(depth_p)-1:0]   rd_addr;
  trace_entry_s                 rd_entry;
  logic                         rd_valid;

  modport master (
    output net_packet, cycle_counter, rd_addr,
    input  rd_entry, rd_valid
  );

  modport slave (
    input  net_packet, cycle_counter, rd_addr,
    output rd_entry, rd_valid
  );

endinterface

// File: rtl/net_packet_trace_buffer_rr_arb.sv
// Round-robin arbiter over the skid slots: one-hot grant to the first requester at or after
// the priority pointer, which then moves one past the grantee when the grant is used.
module net_trace_rr_arb #(
  parameter int channels_p = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [channels_p-1:0] req,
  input  logic                  advance,
  output logic [channels_p-1:0] grant
);

  localparam int ptr_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1;

  logic [ptr_width_lp-1:0] prio_ptr;
  logic [ptr_width_lp-1:0] grant_idx;
  logic                    found;
  int                      idx;

  // Scan requesters starting at the priority pointer, wrapping around the channel count
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < channels_p; i++) begin
      idx = int'(prio_ptr) + i;
      if (idx >= channels_p) idx = idx - channels_p;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ptr_width_lp'(idx);
      end
    end
  end

  // Rotate priority past the channel that actually got serviced; a re-arm restarts at channel 0
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      prio_ptr <= '0;
    end else if (advance && found) begin
      prio_ptr <= (int'(grant_idx) == channels_p - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/net_packet_trace_buffer.sv
// Multi-channel packet trace buffer: filtered packets land in per-channel skid slots, a
// round-robin arbiter moves one slot per cycle into a circular RAM, and an arm/trigger FSM
// decides when capture stops. Read-back is by logical index from the oldest entry.
module net_packet_trace_buffer
  import net_packet_trace_buffer_pkg::*;
#(
  parameter int channels_p   = 4,
  parameter int depth_p      = 64,
  parameter int wrap_mode_p  = 1,
  parameter int drop_width_p = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  net_packet_trace_buffer_if.slave           bus,
  input  logic [(1<<net_op_width_gp)-1:0]    op_filter_i,
  input  logic                               arm_i,
  input  logic                               trig_en_i,
  input  logic [net_op_width_gp-1:0]         trig_op_i,
  input  logic [id_width_gp-1:0]             trig_id_i,
  input  logic [$clog2(depth_p)-1:0]         post_trig_i,
  output logic [$clog2(depth_p):0]           count_o,
  output logic [drop_width_p-1:0]            drop_count_o,
  output trace_state_e                       state_o,
  output logic                               triggered_o
);

  localparam int aw_lp = $clog2(depth_p);

  trace_entry_s ram [depth_p];

  trace_state_e             state, state_next;
  logic [aw_lp-1:0]         wr_ptr, wr_ptr_next, remaining, remaining_next;
  logic [aw_lp:0]           count_next;
  logic [drop_width_p-1:0]  drop_next;
  logic [drop_width_p:0]    drop_total;
  logic                     triggered_next;
  logic [channels_p-1:0]    slot_valid, grant, accept, drop;
  net_packet_s              slot_pkt [channels_p];
  logic [31:0]              slot_cycle [channels_p];
  logic                     capturing, do_write;
  trace_entry_s             wr_entry;
  logic [aw_lp-1:0]         oldest, rd_index;

  assign capturing = ((state == TRACE_ARMED) || (state == TRACE_POST)) && !arm_i;
  assign do_write  = capturing && (|slot_valid);
  assign state_o   = state;
  assign oldest    = wr_ptr - count_o[aw_lp-1:0];
  assign rd_index  = oldest + bus.rd_addr;

  net_trace_rr_arb #(.channels_p(channels_p)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .clear   (arm_i),
    .req     (slot_valid),
    .advance (do_write),
    .grant   (grant)
  );

  // Build the entry for the granted slot and decide per channel whether an arrival fits or drops
  always_comb begin
    wr_entry = '0;
    accept   = '0;
    drop     = '0;
    for (int c = 0; c < channels_p; c++) begin
      if (grant[c]) wr_entry = '{cycle: slot_cycle[c], chan: 3'(c), pkt: slot_pkt[c]};
      if (capturing && pkt_capturable(bus.net_packet[c], op_filter_i)) begin
        if (!slot_valid[c] || grant[c]) accept[c] = 1'b1;
        else                            drop[c]   = 1'b1;
      end
    end
  end

  // Capture FSM plus pointer, occupancy, trigger and saturating drop bookkeeping
  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    count_next     = count_o;
    remaining_next = remaining;
    triggered_next = triggered_o;
    drop_total     = {1'b0, drop_count_o} + (drop_width_p+1)'($countones(drop));
    drop_next      = drop_total[drop_width_p] ? '1 : drop_total[drop_width_p-1:0];
    if (arm_i) begin
      state_next     = TRACE_ARMED;
      wr_ptr_next    = '0;
      count_next     = '0;
      remaining_next = '0;
      triggered_next = 1'b0;
      drop_next      = '0;
    end else if (do_write) begin
      wr_ptr_next = wr_ptr + 1'b1;
      if (count_o != (aw_lp+1)'(depth_p)) count_next = count_o + 1'b1;
      if (state == TRACE_ARMED && trig_en_i &&
          wr_entry.pkt.net_op == net_op_e'(trig_op_i) && wr_entry.pkt.id == trig_id_i) begin
        triggered_next = 1'b1;
        remaining_next = post_trig_i;
        state_next     = (post_trig_i == '0) ? TRACE_FROZEN : TRACE_POST;
      end else if (state == TRACE_POST) begin
        remaining_next = remaining - 1'b1;
        if (remaining == aw_lp'(1)) state_next = TRACE_FROZEN;
      end
      if (wrap_mode_p == 0 && count_o == (aw_lp+1)'(depth_p - 1)) state_next = TRACE_FROZEN;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= TRACE_IDLE;
      wr_ptr       <= '0;
      count_o      <= '0;
      remaining    <= '0;
      triggered_o  <= 1'b0;
      drop_count_o <= '0;
    end else begin
      state        <= state_next;
      wr_ptr       <= wr_ptr_next;
      count_o      <= count_next;
      remaining    <= remaining_next;
      triggered_o  <= triggered_next;
      drop_count_o <= drop_next;
    end
  end

  // Skid occupancy: flushed whenever capture is off, refilled on accept, emptied on grant
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_valid <= '0;
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        if (!capturing)    slot_valid[c] <= 1'b0;
        else if (accept[c]) slot_valid[c] <= 1'b1;
        else if (grant[c])  slot_valid[c] <= 1'b0;
      end
    end
  end

  // Skid payload, timestamped at the moment the packet is accepted
  always_ff @(posedge clk) begin
    for (int c = 0; c < channels_p; c++) begin
      if (accept[c]) begin
        slot_pkt[c]   <= bus.net_packet[c];
        slot_cycle[c] <= bus.cycle_counter;
      end
    end
  end

  // Trace RAM write port
  always_ff @(posedge clk) begin
    if (do_write) ram[wr_ptr] <= wr_entry;
  end

  // Registered read by logical index; indices past the fill level read back as empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_entry <= '0;
    end else if ({1'b0, bus.rd_addr} < count_o) begin
      bus.rd_valid <= 1'b1;
      bus.rd_entry <= ram[rd_index];
    end else begin
      bus.rd_valid <= 1'b0;
      bus.rd_entry <= '0;
    end
  end

endmodule
